// File: rtl/cnn_acc_requant_if.sv
// Stream bundle for cnn_acc_requant: product beats in, requantized window results out.
interface cnn_acc_requant_if #(
  parameter int unsigned DIN_WIDTH  = 22,
  parameter int unsigned DOUT_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
);
  logic                  in_valid;
  logic                  in_last;
  logic [DIN_WIDTH-1:0]  in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [DOUT_WIDTH-1:0] out_data;
  logic [CNT_WIDTH-1:0]  out_count;

  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/cnn_acc_requant.sv
// Window accumulator with round-half-up requantization and a single-entry output register.
// Optional CNN_ACC_SAT_EN: saturate out_data to all ones on range overflow or in-window carry.
module cnn_acc_requant #(
  parameter int unsigned DIN_WIDTH  = 22,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned SHIFT      = 8,
  parameter int unsigned DOUT_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic               clk,
  input  logic               reset,
  cnn_acc_requant_if.slave   bus,
  output logic               ovf
);
  localparam int unsigned SUM_W = ACC_WIDTH + 2;
  localparam int unsigned R_W   = SUM_W - SHIFT;

  logic [ACC_WIDTH-1:0]  acc;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  accept_c;
  logic [ACC_WIDTH:0]    sum_c;
  logic [SUM_W-1:0]      rnd_c;
  logic [R_W-1:0]        r_c;
  logic [DOUT_WIDTH-1:0] q_c;

  // Output register drains in the same cycle it reloads, so ready only drops while stalled.
  assign bus.in_ready = !bus.out_valid | bus.out_ready;
  assign accept_c     = bus.in_valid & bus.in_ready;

  assign sum_c = {1'b0, acc} + (ACC_WIDTH+1)'(bus.in_data);
  assign rnd_c = SUM_W'(sum_c) + (SUM_W'(1) << (SHIFT - 1));
  assign r_c   = R_W'(rnd_c >> SHIFT);

`ifdef CNN_ACC_SAT_EN
  localparam logic [SUM_W-1:0] Q_MAX = SUM_W'((64'd1 << DOUT_WIDTH) - 64'd1);
  logic win_ovf;

  always_comb begin
    q_c = DOUT_WIDTH'(r_c);
    if (win_ovf || sum_c[ACC_WIDTH] || (SUM_W'(r_c) > Q_MAX)) q_c = '1;
  end

  // Carry seen earlier in the current window; cleared when the window closes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_ovf <= 1'b0;
    end else if (accept_c) begin
      if (bus.in_last)         win_ovf <= 1'b0;
      else if (sum_c[ACC_WIDTH]) win_ovf <= 1'b1;
    end
  end
`else
  assign q_c = DOUT_WIDTH'(r_c);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc           <= '0;
      cnt           <= '0;
      ovf           <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_count <= '0;
    end else begin
      if (bus.out_ready) bus.out_valid <= 1'b0;
      if (accept_c) begin
        if (sum_c[ACC_WIDTH]) ovf <= 1'b1;
        if (bus.in_last) begin
          bus.out_data  <= q_c;
          bus.out_count <= cnt + CNT_WIDTH'(1);
          bus.out_valid <= 1'b1;
          acc           <= '0;
          cnt           <= '0;
        end else begin
          acc <= sum_c[ACC_WIDTH-1:0];
          cnt <= cnt + CNT_WIDTH'(1);
        end
      end
    end
  end
endmodule
